// File: rtl/bcd_stream_decoder.sv
// Serialises a packed NDIG-digit BCD word, most significant digit first, as one-hot decimal beats.
// Latency 1 clk from acceptance to the first beat; outputs hold exactly while out_ready is low.
module bcd_stream_decoder #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [9:0]        dec_out,
  output logic              err,
  output logic [3:0]        digit_idx,
  output logic              out_last
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [3:0] TOP = 4'(NDIG - 1);

  state_t              state_q, state_d;
  logic [4*NDIG-1:0]   word_q, word_d;
  logic [3:0]          ptr_q, ptr_d;
  logic                rdy_q, rdy_d;
  logic                vld_q, vld_d;
  logic [9:0]          dec_q, dec_d;
  logic                err_q, err_d;
  logic [3:0]          idx_q, idx_d;
  logic                last_q, last_d;
  logic [3:0]          ptr_nxt;
  logic [10:0]         dcd;

  function automatic logic [3:0] nib_at(input logic [4*NDIG-1:0] w, input logic [3:0] k);
    nib_at = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (4'(i) == k) nib_at = w[4*i +: 4];
    end
  endfunction

  // Returns {err, one-hot}; codes 10..15 give an all-zero one-hot with err set.
  function automatic logic [10:0] decode(input logic [3:0] v);
    decode = 11'h400;
    if (v <= 4'd9) decode = {1'b0, 10'b1 << v};
  endfunction

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    ptr_d   = ptr_q;
    rdy_d   = rdy_q;
    vld_d   = vld_q;
    dec_d   = dec_q;
    err_d   = err_q;
    idx_d   = idx_q;
    last_d  = last_q;
    ptr_nxt = ptr_q - 4'd1;
    dcd     = 11'd0;
    case (state_q)
      IDLE: begin
        if (in_valid && rdy_q) begin
          state_d        = EMIT;
          word_d         = bcd_in;
          ptr_d          = TOP;
          rdy_d          = 1'b0;
          vld_d          = 1'b1;
          dcd            = decode(nib_at(bcd_in, TOP));
          {err_d, dec_d} = dcd;
          idx_d          = TOP;
          last_d         = (TOP == 4'd0);
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (ptr_q != 4'd0) begin
            ptr_d          = ptr_nxt;
            dcd            = decode(nib_at(word_q, ptr_nxt));
            {err_d, dec_d} = dcd;
            idx_d          = ptr_nxt;
            last_d         = (ptr_nxt == 4'd0);
          end else begin
            state_d = IDLE;
            word_d  = '0;
            rdy_d   = 1'b1;
            vld_d   = 1'b0;
            dec_d   = 10'd0;
            err_d   = 1'b0;
            idx_d   = 4'd0;
            last_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      ptr_q   <= 4'd0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      dec_q   <= 10'd0;
      err_q   <= 1'b0;
      idx_q   <= 4'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      ptr_q   <= ptr_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      dec_q   <= dec_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign dec_out   = dec_q;
  assign err       = err_q;
  assign digit_idx = idx_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_bcd_stream_decoder.sv
// Directed bench for bcd_stream_decoder: a 4-digit and a 1-digit instance sharing clock and reset.
module tb_bcd_stream_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic [15:0] bcd_in = 16'h0;
  logic        in_ready, out_valid, err, out_last;
  logic [9:0]  dec_out;
  logic [3:0]  digit_idx;

  logic        in_valid1 = 1'b0, out_ready1 = 1'b1;
  logic [3:0]  bcd_in1 = 4'h0;
  logic        in_ready1, out_valid1, err1, out_last1;
  logic [9:0]  dec_out1;
  logic [3:0]  digit_idx1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bcd_stream_decoder #(.NDIG(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .bcd_in(bcd_in),
    .out_valid(out_valid), .out_ready(out_ready), .dec_out(dec_out), .err(err),
    .digit_idx(digit_idx), .out_last(out_last)
  );

  bcd_stream_decoder #(.NDIG(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .bcd_in(bcd_in1),
    .out_valid(out_valid1), .out_ready(out_ready1), .dec_out(dec_out1), .err(err1),
    .digit_idx(digit_idx1), .out_last(out_last1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({out_valid, dec_out, err, digit_idx, out_last} !== 17'd0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b dec=%h err=%b idx=%0d last=%b want all 0",
               out_valid, dec_out, err, digit_idx, out_last);
    end
    total++;
    if ({out_valid1, dec_out1, err1} !== 12'd0) begin
      bad++;
      $display("FAIL reset_outputs_n1 got v=%b dec=%h err=%b want all 0", out_valid1, dec_out1, err1);
    end
    step();
    rst_n = 1'b1;
    step();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  // Accepts one word (in_ready checked), then checks four beats with out_ready held high.
  task automatic run_word(input string name, input logic [15:0] w,
                          input logic [39:0] exp_dec, input logic [3:0] exp_err);
    out_ready = 1'b1;
    bcd_in    = w;
    in_valid  = 1'b1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_accept_rdy got %b want 1", name, in_ready);
    end
    step();
    in_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      total++;
      if (out_valid !== 1'b1 || dec_out !== exp_dec[10*(3-b) +: 10] || err !== exp_err[3-b] ||
          digit_idx !== 4'(3-b) || out_last !== (b == 3)) begin
        bad++;
        $display("FAIL %s_beat%0d got v=%b dec=%h err=%b idx=%0d last=%b want v=1 dec=%h err=%b idx=%0d last=%b",
                 name, b, out_valid, dec_out, err, digit_idx, out_last,
                 exp_dec[10*(3-b) +: 10], exp_err[3-b], 3-b, (b == 3));
      end
      step();
    end
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_done got v=%b rdy=%b want v=0 rdy=1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_decode();
    run_word("dec1905", 16'h1905, {10'h002, 10'h200, 10'h001, 10'h020}, 4'b0000);
  endtask

  task automatic test_invalid_nibble();
    run_word("inv12A4", 16'h12A4, {10'h002, 10'h004, 10'h000, 10'h010}, 4'b0010);
  endtask

  task automatic test_backpressure();
    bcd_in   = 16'h0789;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total++;
    if (dec_out !== 10'h001 || digit_idx !== 4'd3) begin
      bad++;
      $display("FAIL bp_beat0 got dec=%h idx=%0d want dec=001 idx=3", dec_out, digit_idx);
    end
    step();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (out_valid !== 1'b1 || dec_out !== 10'h080 || digit_idx !== 4'd2 || out_last !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d got v=%b dec=%h idx=%0d last=%b want v=1 dec=080 idx=2 last=0",
                 c, out_valid, dec_out, digit_idx, out_last);
      end
      if (c < 4) step();
    end
    out_ready = 1'b1;
    step();
    total++;
    if (dec_out !== 10'h100 || digit_idx !== 4'd1) begin
      bad++;
      $display("FAIL bp_resume1 got dec=%h idx=%0d want dec=100 idx=1", dec_out, digit_idx);
    end
    step();
    total++;
    if (dec_out !== 10'h200 || digit_idx !== 4'd0 || out_last !== 1'b1) begin
      bad++;
      $display("FAIL bp_resume2 got dec=%h idx=%0d last=%b want dec=200 idx=0 last=1",
               dec_out, digit_idx, out_last);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_done got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] exp2;
    exp2 = {10'h010, 10'h008, 10'h004, 10'h002};
    bcd_in   = 16'h5555;
    in_valid = 1'b1;
    step();
    bcd_in = 16'h4321;
    for (int b = 0; b < 4; b++) begin
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || dec_out !== 10'h020 || digit_idx !== 4'(3-b)) begin
        bad++;
        $display("FAIL busy_beat%0d got rdy=%b v=%b dec=%h idx=%0d want rdy=0 v=1 dec=020 idx=%0d",
                 b, in_ready, out_valid, dec_out, digit_idx, 3-b);
      end
      step();
    end
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL busy_idle got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    end
    step();
    in_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      total++;
      if (out_valid !== 1'b1 || dec_out !== exp2[10*(3-b) +: 10] || digit_idx !== 4'(3-b)) begin
        bad++;
        $display("FAIL next_beat%0d got v=%b dec=%h idx=%0d want v=1 dec=%h idx=%0d",
                 b, out_valid, dec_out, digit_idx, exp2[10*(3-b) +: 10], 3-b);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    bcd_in   = 16'h1905;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    total++;
    if (dec_out !== 10'h200 || digit_idx !== 4'd2) begin
      bad++;
      $display("FAIL ar_beat2 got dec=%h idx=%0d want dec=200 idx=2", dec_out, digit_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || dec_out !== 10'h000 || err !== 1'b0) begin
      bad++;
      $display("FAIL ar_immediate got v=%b dec=%h err=%b want 0", out_valid, dec_out, err);
    end
    step();
    #2 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL ar_stale%0d got rdy=%b v=%b want rdy=1 v=0", c, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_ndig1();
    logic [3:0]  vals [2];
    logic [9:0]  edec [2];
    logic        eerr [2];
    vals[0] = 4'h7; edec[0] = 10'h080; eerr[0] = 1'b0;
    vals[1] = 4'hF; edec[1] = 10'h000; eerr[1] = 1'b1;
    for (int t = 0; t < 2; t++) begin
      bcd_in1   = vals[t];
      in_valid1 = 1'b1;
      step();
      in_valid1 = 1'b0;
      total++;
      if (out_valid1 !== 1'b1 || dec_out1 !== edec[t] || err1 !== eerr[t] ||
          digit_idx1 !== 4'd0 || out_last1 !== 1'b1) begin
        bad++;
        $display("FAIL n1_beat_%h got v=%b dec=%h err=%b idx=%0d last=%b want v=1 dec=%h err=%b idx=0 last=1",
                 vals[t], out_valid1, dec_out1, err1, digit_idx1, out_last1, edec[t], eerr[t]);
      end
      step();
      total++;
      if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
        bad++;
        $display("FAIL n1_done_%h got v=%b rdy=%b want v=0 rdy=1", vals[t], out_valid1, in_ready1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_invalid_nibble();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_ndig1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_stream_decoder.md
Name: bcd_stream_decoder

Overview:
- Reverse direction of the team's decimal-to-BCD priority encoder: accepts a packed multi-digit BCD word and emits it one digit per beat as a 10-bit one-hot decimal line.
- Most-significant digit first; nibble values 10–15 are flagged as errors.
- Valid/ready handshake on both sides; drives downstream one-hot consumers such as display digit drivers and scanned 10-line outputs.
- All outputs registered.

Parameters:
- NDIG, 4, number of BCD digits per input word; legal range 1..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  bcd_in holds a word to decode.
- in_ready  output  1  block can accept a word this cycle.
- bcd_in  input  4*NDIG  packed BCD; digit k occupies bits [4k+3:4k]; digit NDIG-1 is most significant.
- out_valid  output  1  dec_out/err/digit_idx/out_last are valid.
- out_ready  input  1  downstream accepts the current beat.
- dec_out  output  10  one-hot decimal; bit n set for digit value n (0..9); all zero on error.
- err  output  1  current nibble is 10..15.
- digit_idx  output  4  index k of the digit being presented.
- out_last  output  1  current beat is digit 0, the last of the word.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state = IDLE; in_ready = 1 once reset deasserts.
  - out_valid, dec_out, err, digit_idx, out_last all 0.
  - Latched word is cleared; a word in progress is discarded.
- FSM states: IDLE, EMIT.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid && in_ready, latch bcd_in, set digit pointer to NDIG-1, go to EMIT.
- EMIT:
  - in_ready = 0; in_valid is ignored and the word is not consumed.
  - out_valid = 1 from the cycle after acceptance (latency 1 clk).
  - dec_out, err, digit_idx, out_last are registered decodes of the latched nibble at the pointer.
- Beat transfer occurs on out_valid && out_ready:
  - If pointer > 0: decrement pointer and present the next digit in the following cycle. out_valid stays 1, with no bubble between beats.
  - If pointer == 0 (out_last = 1): go to IDLE. out_valid = 0 and in_ready = 1 in the next cycle.
- Backpressure: while out_valid && !out_ready, all output registers hold exactly; the latched word and pointer are unchanged.
- Decode rules:
  - Nibble v in 0..9: dec_out = 1 << v, err = 0.
  - Nibble 10..15: dec_out = 10'b0, err = 1. The beat is still emitted and counts toward the word; no abort.
- out_last = 1 iff digit_idx == 0. For NDIG = 1, every beat has out_last = 1 and digit_idx = 0.
- digit_idx is zero-extended to 4 bits.
- Throughput: NDIG beats per word, plus one IDLE cycle between words.
- dec_out is never x. No output has a multi-hot value.

Test Plan:
- Reset then decode: NDIG=4, bcd_in=16'h1905, out_ready=1.
  - in_ready high in IDLE; in_valid is accepted.
  - Beats on the next 4 cycles: dec_out = 10'h002, 10'h200, 10'h001, 10'h020; digit_idx = 3, 2, 1, 0; out_last only on the 4th; err = 0 throughout.
  - Then out_valid = 0 and in_ready = 1.
- Invalid nibble: bcd_in=16'h12A4.
  - 3rd beat: dec_out = 10'h000, err = 1, digit_idx = 1.
  - 4th beat: dec_out = 10'h010, err = 0.
  - Word completes normally.
- Backpressure: hold out_ready=0 for 5 cycles during beat 2 of 16'h0789.
  - dec_out stays 10'h080 and digit_idx stays 2 for all 5 cycles.
  - Resumes with 10'h100, then 10'h200 once out_ready=1.
- Busy input: keep in_valid=1 with a new word (16'h4321) during EMIT of 16'h5555.
  - in_ready = 0; all four beats are 10'h020.
  - 16'h4321 is accepted only in the IDLE cycle after out_last.
- Async reset mid-word: assert rst_n=0 between clock edges during beat 2.
  - out_valid, dec_out, err immediately 0.
  - After release, in_ready = 1 and no stale beats appear.
- NDIG=1 instance: bcd_in=4'h7 → one beat, dec_out = 10'h080, out_last = 1, digit_idx = 0.
- NDIG=1 instance: bcd_in=4'hF → one beat, dec_out = 10'h000, err = 1.
